// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - DES key schedule: PC-1 then per-round C/D rotation, one CD word per handshake
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (adds parity_err output)

module des_key_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  output logic [1:56] cd_out,
  output logic        cd_valid,
  input  logic        cd_ready,
  output logic [4:0]  round,
  output logic        busy,
  output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        parity_err
`endif
);

  typedef enum logic {IDLE, ROUND} stateT;

  stateT      state;
  logic       decQ;
  logic [1:56] keyPc1;
  logic [4:0] shiftIdx;

  // PC-1 drops the parity bits and splits the key into C (first 28) and D (last 28)
  function automatic logic [1:56] pc1(input logic [1:64] k);
    return {k[57], k[49], k[41], k[33], k[25], k[17], k[9],  k[1],
            k[58], k[50], k[42], k[34], k[26], k[18], k[10], k[2],
            k[59], k[51], k[43], k[35], k[27], k[19], k[11], k[3],
            k[60], k[52], k[44], k[36],
            k[63], k[55], k[47], k[39], k[31], k[23], k[15], k[7],
            k[62], k[54], k[46], k[38], k[30], k[22], k[14], k[6],
            k[61], k[53], k[45], k[37], k[29], k[21], k[13], k[5],
            k[28], k[20], k[12], k[4]};
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] h, input logic two);
    return two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] h, input logic two);
    return two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
  endfunction

  // C and D rotate independently; decrypt walks the schedule backwards
  function automatic logic [1:56] stepCd(input logic [1:56] cd, input logic dec, input logic two);
    return dec ? {rotr(cd[1:28], two), rotr(cd[29:56], two)}
               : {rotl(cd[1:28], two), rotl(cd[29:56], two)};
  endfunction

  // Shift table entry S[idx] is 1 for rounds 1, 2, 9 and 16, otherwise 2
  function automatic logic isDouble(input logic [4:0] idx);
    return !(idx == 5'd1 || idx == 5'd2 || idx == 5'd9 || idx == 5'd16);
  endfunction

  assign keyPc1 = pc1(key_in);

  // Encrypt moving to round r+1 uses S[r+1]; decrypt undoing round 17-r uses S[17-r]
  assign shiftIdx = decQ ? (5'd17 - round) : (round + 5'd1);

`ifdef DES_KEY_PARITY_CHECK_EN
  // A DES key byte is valid only with odd parity
  function automatic logic anyEvenByte(input logic [1:64] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) e = e | ~^k[8*b+1 +: 8];
    return e;
  endfunction
`else
  logic unusedParityBits;
  assign unusedParityBits = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                              key_in[40], key_in[48], key_in[56], key_in[64]};
`endif

  // Schedule FSM: load on start, advance one round per accepted word, pulse done after round 16
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      decQ     <= 1'b0;
      cd_out   <= '0;
      cd_valid <= 1'b0;
      round    <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef DES_KEY_PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ROUND;
            decQ     <= decrypt;
            // Decrypt starts at C16D16, which equals C0D0 since the total rotation is 28
            cd_out   <= decrypt ? keyPc1 : stepCd(keyPc1, 1'b0, 1'b0);
            round    <= 5'd1;
            busy     <= 1'b1;
            cd_valid <= 1'b1;
`ifdef DES_KEY_PARITY_CHECK_EN
            parity_err <= anyEvenByte(key_in);
`endif
          end
        end
        ROUND: begin
          if (cd_ready) begin
            if (round == 5'd16) begin
              state    <= IDLE;
              cd_valid <= 1'b0;
              busy     <= 1'b0;
              round    <= 5'd0;
              done     <= 1'b1;
            end else begin
              round  <= round + 5'd1;
              cd_out <= stepCd(cd_out, decQ, isDouble(shiftIdx));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard bench for des_key_schedule (honours DES_KEY_PARITY_CHECK_EN)

module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:64] keyIn;
  logic        decrypt;
  logic [1:56] cdOut;
  logic        cdValid;
  logic        cdReady;
  logic [4:0]  round;
  logic        busy;
  logic        done;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic        parityErr;
`endif

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (keyIn),
    .decrypt  (decrypt),
    .cd_out   (cdOut),
    .cd_valid (cdValid),
    .cd_ready (cdReady),
    .round    (round),
    .busy     (busy),
    .done     (done)
`ifdef DES_KEY_PARITY_CHECK_EN
    ,
    .parity_err (parityErr)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rnd;
    logic [55:0] cd;
  } expT;

  typedef struct {
    logic [63:0] key;
    logic        dec;
    logic [55:0] r1;
    logic [55:0] r2;
    logic [55:0] r16;
    bit          known;
  } vecT;

  expT         sbQ[$];
  expT         popped;
  logic [55:0] seen [1:16];
  bit          expectDone = 1'b0;
  vecT         vecs [6];

  int pc1Tab[56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2,
                     59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6,
                     61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int shiftTab[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] pc1Model(input logic [63:0] k);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[55-i] = k[64-pc1Tab[i]];
    return o;
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] h, input int n);
    logic [27:0] r;
    r = h;
    for (int i = 0; i < n; i++) r = {r[26:0], r[27]};
    return r;
  endfunction

  // Round r carries K(r) for encrypt, K(17-r) for decrypt; K(j) = PC1 rotated by sum S[1..j]
  function automatic logic [55:0] modelRound(input logic [63:0] k, input bit dec, input int r);
    logic [55:0] base;
    int idx;
    int tot;
    idx  = dec ? 17 - r : r;
    tot  = 0;
    for (int i = 0; i < idx; i++) tot += shiftTab[i];
    base = pc1Model(k);
    return {rot28(base[55:28], tot), rot28(base[27:0], tot)};
  endfunction

  function automatic bit modelParity(input logic [63:0] k);
    bit e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) e = 1'b1;
    return e;
  endfunction

  task automatic pushSchedule(input logic [63:0] k, input bit dec);
    expT e;
    for (int r = 1; r <= 16; r++) begin
      e.rnd = 5'(r);
      e.cd  = modelRound(k, dec, r);
      sbQ.push_back(e);
    end
  endtask

  task automatic startSchedule(input logic [63:0] k, input bit dec);
    keyIn   = k;
    decrypt = dec;
    start   = 1'b1;
    pushSchedule(k, dec);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("latency_valid", 64'(cdValid), 64'd1);
    check("latency_round", 64'(round), 64'd1);
    check("latency_busy", 64'(busy), 64'd1);
`ifdef DES_KEY_PARITY_CHECK_EN
    check("parity_err", 64'(parityErr), 64'(modelParity(k)));
`endif
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    check({name, "_queue_empty"}, 64'(sbQ.size()), 64'd0);
  endtask

  task automatic waitRound(input logic [4:0] r);
    int n;
    n = 0;
    while (round != r && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_round", 64'(round), 64'(r));
  endtask

  // Monitor: compare each accepted word with the scoreboard, and track the done pulse
  always @(negedge clk) begin
    if (rst) begin
      expectDone = 1'b0;
    end else begin
      check("done_pulse", 64'(done), 64'(expectDone));
      if (expectDone) begin
        check("idle_valid", 64'(cdValid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_round", 64'(round), 64'd0);
      end
      expectDone = 1'b0;
      if (cdValid && cdReady) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got round %0d cd %h, expected no word", round, cdOut);
        end else begin
          popped = sbQ.pop_front();
          check("sb_round", 64'(round), 64'(popped.rnd));
          check("sb_cd_out", 64'(cdOut), 64'(popped.cd));
        end
        if (round >= 5'd1 && round <= 5'd16) seen[int'(round)] = cdOut;
        if (round == 5'd16) expectDone = 1'b1;
      end
    end
  end

  initial begin
    logic [55:0] snap;
    int n;
    logic [63:0] keyA;
    logic [63:0] keyB;

    vecs[0] = '{64'h133457799BBCDFF1, 1'b0, 56'hE19955FAACCF1E, 56'hC332ABF5599E3D, 56'hF0CCAAF556678F, 1'b1};
    vecs[1] = '{64'h133457799BBCDFF1, 1'b1, 56'hF0CCAAF556678F, 56'hF866557AAB33C7, 56'hE19955FAACCF1E, 1'b1};
    vecs[2] = '{64'h0101010101010101, 1'b0, 56'h0, 56'h0, 56'h0, 1'b1};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, 56'hFFFFFFFFFFFFFF, 1'b1};
    vecs[4] = '{{$urandom, $urandom}, 1'b0, 56'h0, 56'h0, 56'h0, 1'b0};
    vecs[5] = '{{$urandom, $urandom}, 1'b1, 56'h0, 56'h0, 56'h0, 1'b0};

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; cdReady = 1'b1; keyIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cd_out", 64'(cdOut), 64'd0);
    check("reset_valid", 64'(cdValid), 64'd0);
    check("reset_round", 64'(round), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
`ifdef DES_KEY_PARITY_CHECK_EN
    check("reset_parity_err", 64'(parityErr), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors, back-to-back with cd_ready high
    for (int i = 0; i < 6; i++) begin
      for (int r = 1; r <= 16; r++) seen[r] = 'x;
      startSchedule(vecs[i].key, vecs[i].dec);
      waitDone("vector");
      if (vecs[i].known) begin
        check("vec_round1", 64'(seen[1]), 64'(vecs[i].r1));
        check("vec_round2", 64'(seen[2]), 64'(vecs[i].r2));
        check("vec_round16", 64'(seen[16]), 64'(vecs[i].r16));
      end
    end
    check("hold_after_done", 64'(cdOut), 64'(vecs[5].r16 | modelRound(vecs[5].key, 1'b1, 16)));

    // Backpressure: stall 5 cycles at round 3
    startSchedule(64'h0E329232EA6D0D73, 1'b0);
    waitRound(5'd3);
    cdReady = 1'b0;
    snap = cdOut;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("stall_cd_out", 64'(cdOut), 64'(snap));
      check("stall_round", 64'(round), 64'd3);
      check("stall_valid", 64'(cdValid), 64'd1);
    end
    cdReady = 1'b1;
    waitDone("stall");

    // Random backpressure, decrypt order
    startSchedule({$urandom, $urandom}, 1'b1);
    n = 0;
    while (!done && n < 300) begin
      cdReady = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    cdReady = 1'b1;
    waitDone("random_ready");

    // Start during a schedule is ignored; start in the done cycle is accepted
    keyA = 64'h0123456789ABCDEF;
    keyB = 64'hFEDCBA9876543210;
    startSchedule(keyA, 1'b0);
    waitRound(5'd7);
    keyIn = keyB; decrypt = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("ignored_start");
    startSchedule(keyB, 1'b0);
    waitDone("back_to_back");

    // Asynchronous reset mid-schedule at round 9
    startSchedule(keyA, 1'b1);
    waitRound(5'd9);
    #3;
    rst = 1'b1;
    #1;
    check("abort_cd_out", 64'(cdOut), 64'd0);
    check("abort_valid", 64'(cdValid), 64'd0);
    check("abort_round", 64'(round), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    startSchedule(keyB, 1'b1);
    check("post_reset_round1", 64'(cdOut), 64'(pc1Model(keyB)));
    waitDone("post_reset");

`ifdef DES_KEY_PARITY_CHECK_EN
    startSchedule(64'h133457799BBCDFF0, 1'b0);
    check("parity_bad_key", 64'(parityErr), 64'd1);
    waitDone("parity_bad");
    check("parity_hold", 64'(parityErr), 64'd1);
    startSchedule(64'h133457799BBCDFF1, 1'b0);
    check("parity_good_key", 64'(parityErr), 64'd0);
    waitDone("parity_good");
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
